// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter and instruction-fetch controller for the CPU front end.
// Holds the architectural PC and fetches the instruction at that PC over a
// req/ack handshake. When the datapath commits, it loads one of four next-PC
// sources: sequential, branch, jump or jr. A halt request freezes the unit
// until reset.
//
// Ports
//   CLK           in   1   system clock, rising edge
//   Reset         in   1   asynchronous active-low reset
//   PCWre         in   1   commit strobe; PC may advance (VALID only)
//   PCSrc         in   2   next-PC select: 00 seq, 01 branch, 10 jump, 11 jr
//   branchOffset  in  32   sign-extended branch immediate, in words
//   jumpTarget    in  26   J-type target field
//   regAddr       in  32   jr target from the register file
//   halt          in   1   stop after the current instruction
//   memReq        out  1   instruction read request
//   memAddr       out 32   read address (current PC)
//   memAck        in   1   memory returns data this cycle
//   memData       in  32   instruction word, valid with memAck
//   instr         out 32   latched instruction
//   instrValid    out  1   instr belongs to the current PC
//   curPC         out 32   current PC
//   seqPC         out 32   curPC + 4
//   halted        out  1   unit is in HALT
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branchOffset,
  input  logic [25:0] jumpTarget,
  input  logic [31:0] regAddr,
  input  logic        halt,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] curPC,
  output logic [31:0] seqPC,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] seq_pc;

  assign seq_pc = pc_q + 32'd4;

  // Branch target: word offset scaled to bytes, added to PC+4, wraps mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] seq,
                                                input logic signed [31:0] off_words);
    logic signed [31:0] off_bytes;
    off_bytes = off_words <<< 2;
    return seq + $unsigned(off_bytes);
  endfunction

  function automatic logic [31:0] next_pc(input logic [1:0]  src,
                                          input logic [31:0] seq,
                                          input logic [31:0] off,
                                          input logic [25:0] tgt,
                                          input logic [31:0] ra);
    logic [31:0] npc;
    case (src)
      2'b00:   npc = seq;
      2'b01:   npc = branch_target(seq, $signed(off));
      2'b10:   npc = {seq[31:28], tgt, 2'b00};
      default: npc = {ra[31:2], 2'b00};   // jr: misaligned low bits dropped
    endcase
    return npc;
  endfunction

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (memAck) begin
          instr_d = memData;
          state_d = VALID;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (memAck) begin
          instr_d = memData;
          state_d = VALID;
        end
      end
      VALID: begin
        // halt takes priority over a simultaneous commit and keeps the PC
        if (halt) begin
          state_d = HALT;
        end else if (PCWre) begin
          pc_d    = next_pc(PCSrc, seq_pc, branchOffset, jumpTarget, regAddr);
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  // Outputs. memReq is qualified by Reset so an in-flight request drops the
  // instant reset asserts, and stays low for the whole reset period even
  // though the state register already reads FETCH.
  always_comb begin
    memReq     = Reset && ((state_q == FETCH) || (state_q == WAIT));
    instrValid = (state_q == VALID);
    halted     = (state_q == HALT);
  end

  assign memAddr = pc_q;
  assign curPC   = pc_q;
  assign seqPC   = seq_pc;
  assign instr   = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] branchOffset;
  logic [25:0] jumpTarget;
  logic [31:0] regAddr;
  logic        halt;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] curPC;
  logic [31:0] seqPC;
  logic        halted;

  int vecs = 0;
  int errs = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .branchOffset(branchOffset), .jumpTarget(jumpTarget), .regAddr(regAddr),
    .halt(halt), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memData(memData), .instr(instr), .instrValid(instrValid),
    .curPC(curPC), .seqPC(seqPC), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Zero-wait fetch: must be called while the unit is in FETCH.
  task automatic fetch0(input logic [31:0] d);
    memAck  = 1'b1;
    memData = d;
    tick();
    memAck  = 1'b0;
  endtask

  // Commit with a given PC source: must be called while the unit is in VALID.
  task automatic commit(input logic [1:0] src);
    PCSrc = src;
    PCWre = 1'b1;
    tick();
    PCWre = 1'b0;
    PCSrc = 2'b00;
  endtask

  task automatic test_reset();
    Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'b00; branchOffset = 32'h0;
    jumpTarget = 26'h0; regAddr = 32'h0; halt = 1'b0; memAck = 1'b0; memData = 32'h0;
    #2;
    vecs++; if (memReq !== 1'b0) begin errs++; $display("FAIL rst_memReq got %b exp 0", memReq); end
    vecs++; if (instrValid !== 1'b0) begin errs++; $display("FAIL rst_instrValid got %b exp 0", instrValid); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL rst_instr got %h exp 0", instr); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted got %b exp 0", halted); end
    vecs++; if (curPC !== 32'h0) begin errs++; $display("FAIL rst_curPC got %h exp 0", curPC); end
    tick();
    Reset = 1'b1;
    #1;
    // first cycle after reset release: request at PC 0
    vecs++; if (memReq !== 1'b1) begin errs++; $display("FAIL first_memReq got %b exp 1", memReq); end
    vecs++; if (memAddr !== 32'h0) begin errs++; $display("FAIL first_memAddr got %h exp 0", memAddr); end
    vecs++; if (seqPC !== 32'h4) begin errs++; $display("FAIL first_seqPC got %h exp 4", seqPC); end
    fetch0(32'hDEAD_BEEF);
    vecs++; if (instrValid !== 1'b1) begin errs++; $display("FAIL zw_instrValid got %b exp 1", instrValid); end
    vecs++; if (instr !== 32'hDEAD_BEEF) begin errs++; $display("FAIL zw_instr got %h exp deadbeef", instr); end
    vecs++; if (memReq !== 1'b0) begin errs++; $display("FAIL zw_memReq got %b exp 0", memReq); end
    commit(2'b00);
    vecs++; if (instrValid !== 1'b0) begin errs++; $display("FAIL seq_instrValid got %b exp 0", instrValid); end
    vecs++; if (memAddr !== 32'h4) begin errs++; $display("FAIL seq_memAddr got %h exp 4", memAddr); end
    vecs++; if (memReq !== 1'b1) begin errs++; $display("FAIL seq_memReq got %b exp 1", memReq); end
  endtask

  task automatic test_wait_states();
    // unit is in FETCH at PC 4; ack arrives on the 4th request cycle
    for (int i = 0; i < 4; i++) begin
      vecs++; if (memReq !== 1'b1) begin errs++; $display("FAIL wait_memReq[%0d] got %b exp 1", i, memReq); end
      vecs++; if (memAddr !== 32'h4) begin errs++; $display("FAIL wait_memAddr[%0d] got %h exp 4", i, memAddr); end
      vecs++; if (instrValid !== 1'b0) begin errs++; $display("FAIL wait_instrValid[%0d] got %b exp 0", i, instrValid); end
      PCWre   = (i == 1);            // commit outside VALID must be ignored
      PCSrc   = 2'b10;
      memAck  = (i == 3);
      memData = 32'h1234_5678;
      tick();
    end
    memAck = 1'b0; PCWre = 1'b0; PCSrc = 2'b00;
    vecs++; if (instrValid !== 1'b1) begin errs++; $display("FAIL wait_valid got %b exp 1", instrValid); end
    vecs++; if (instr !== 32'h1234_5678) begin errs++; $display("FAIL wait_instr got %h exp 12345678", instr); end
    vecs++; if (curPC !== 32'h4) begin errs++; $display("FAIL wait_pc_held got %h exp 4", curPC); end
    // ack in VALID must not overwrite instr
    memAck = 1'b1; memData = 32'hAAAA_5555;
    tick();
    memAck = 1'b0;
    vecs++; if (instr !== 32'h1234_5678) begin errs++; $display("FAIL valid_ack_ignored got %h exp 12345678", instr); end
    vecs++; if (instrValid !== 1'b1) begin errs++; $display("FAIL valid_hold got %b exp 1", instrValid); end
  endtask

  task automatic test_branch();
    regAddr = 32'h0000_0103;
    commit(2'b11);
    vecs++; if (curPC !== 32'h0000_0100) begin errs++; $display("FAIL jr_to_100 got %h exp 00000100", curPC); end
    fetch0(32'h1);
    branchOffset = 32'hFFFF_FFFE;          // -2 words
    commit(2'b01);
    vecs++; if (curPC !== 32'h0000_00FC) begin errs++; $display("FAIL branch_neg got %h exp 000000fc", curPC); end
    fetch0(32'h2);
    branchOffset = 32'h0000_0003;          // +3 words from 0x100
    commit(2'b01);
    vecs++; if (curPC !== 32'h0000_010C) begin errs++; $display("FAIL branch_pos got %h exp 0000010c", curPC); end
    fetch0(32'h3);
    regAddr = 32'hFFFF_FFFC;
    commit(2'b11);
    fetch0(32'h4);
    vecs++; if (seqPC !== 32'h0000_0000) begin errs++; $display("FAIL seqPC_wrap got %h exp 0", seqPC); end
    commit(2'b00);
    vecs++; if (curPC !== 32'h0000_0000) begin errs++; $display("FAIL seq_wrap got %h exp 0", curPC); end
  endtask

  task automatic test_jump();
    fetch0(32'h5);
    regAddr = 32'h4000_0010;
    commit(2'b11);
    fetch0(32'h6);
    jumpTarget = 26'h000_0040;
    commit(2'b10);
    vecs++; if (curPC !== 32'h4000_0100) begin errs++; $display("FAIL jump got %h exp 40000100", curPC); end
    vecs++; if (memAddr !== 32'h4000_0100) begin errs++; $display("FAIL jump_memAddr got %h exp 40000100", memAddr); end
    fetch0(32'h7);
    regAddr = 32'h0000_1003;
    commit(2'b11);
    vecs++; if (curPC !== 32'h0000_1000) begin errs++; $display("FAIL jr_align got %h exp 00001000", curPC); end
  endtask

  task automatic test_halt();
    fetch0(32'h8);
    halt = 1'b1;
    commit(2'b00);                         // halt and PCWre together
    halt = 1'b0;
    vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_flag got %b exp 1", halted); end
    vecs++; if (curPC !== 32'h0000_1000) begin errs++; $display("FAIL halt_pc got %h exp 00001000", curPC); end
    vecs++; if (instrValid !== 1'b0) begin errs++; $display("FAIL halt_instrValid got %b exp 0", instrValid); end
    for (int i = 0; i < 20; i++) begin
      PCWre  = i[0];
      memAck = i[1];
      tick();
      vecs++; if (memReq !== 1'b0 || halted !== 1'b1 || curPC !== 32'h0000_1000) begin
        errs++;
        $display("FAIL halt_hold[%0d] got memReq=%b halted=%b pc=%h exp 0 1 00001000", i, memReq, halted, curPC);
      end
    end
    PCWre = 1'b0; memAck = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    fetch0(32'h9);
    regAddr = 32'h0000_2000;
    commit(2'b11);
    tick();                                // FETCH without ack -> WAIT
    vecs++; if (memReq !== 1'b1 || memAddr !== 32'h0000_2000) begin
      errs++; $display("FAIL wait_pre_rst got memReq=%b addr=%h exp 1 00002000", memReq, memAddr);
    end
    Reset = 1'b0;                          // mid-cycle, no clock edge
    #1;
    vecs++; if (memReq !== 1'b0) begin errs++; $display("FAIL rst_async_memReq got %b exp 0", memReq); end
    vecs++; if (curPC !== 32'h0) begin errs++; $display("FAIL rst_async_pc got %h exp 0", curPC); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL rst_async_instr got %h exp 0", instr); end
    tick();
    Reset = 1'b1;
    #1;
    vecs++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin
      errs++; $display("FAIL refetch_req got memReq=%b addr=%h exp 1 0", memReq, memAddr);
    end
    fetch0(32'hCAFE_F00D);
    vecs++; if (instrValid !== 1'b1 || instr !== 32'hCAFE_F00D) begin
      errs++; $display("FAIL refetch_data got v=%b instr=%h exp 1 cafef00d", instrValid, instr);
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_branch();
    test_jump();
    test_halt();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Sequential program-counter and instruction-fetch controller for the CPU front end. Holds the architectural PC and computes the sequential address internally (PC+4, the same value the PC adder produces). Issues instruction-memory reads over a req/ack handshake and, when the datapath commits, writes one of four next-PC sources back into the PC. It replaces the free-running PC register and closes the loop the PC adder opens.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PCWre  input  1  commit strobe: datapath finished the current instruction, PC may advance.
- PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jr.
- branchOffset  input  32  sign-extended branch immediate, in words.
- jumpTarget  input  26  J-type target field.
- regAddr  input  32  jr target from register file.
- halt  input  1  stop fetching after the current instruction.
- memReq  output  1  instruction read request.
- memAddr  output  32  read address, equal to the current PC.
- memAck  input  1  memory returns data this cycle.
- memData  input  32  instruction word, valid when memAck=1.
- instr  output  32  latched instruction.
- instrValid  output  1  instr is valid for the current PC.
- curPC  output  32  current PC.
- seqPC  output  32  curPC+4, combinational.
- halted  output  1  unit is in HALT.

## Operation
- FSM states are FETCH, WAIT, VALID and HALT. Reset enters FETCH.
- FETCH: assert memReq for one cycle, then go to WAIT. If memAck is already high in FETCH, latch the data and go directly to VALID.
- WAIT: keep memReq high and memAddr stable until memAck. On memAck, latch memData into instr and go to VALID.
- VALID: instrValid=1, memReq=0. Hold until PCWre or halt.
  - PCWre=1, halt=0: load the next PC and go to FETCH.
  - halt=1: go to HALT and keep the PC; halt wins over a simultaneous PCWre.
- HALT: all strobes are low and the PC is frozen. Only Reset exits HALT.
- PCWre or PCSrc outside VALID are ignored.
- Next-PC arithmetic, all mod 2^32 with wrap-around and no flag:
  - seq: curPC+4.
  - branch: curPC+4 + (branchOffset<<2); a negative offset moves the PC backward.
  - jump: {seqPC[31:28], jumpTarget, 2'b00}.
  - jr: {regAddr[31:2], 2'b00}; misaligned low bits are forced to 0.
- memData is sampled only when memAck=1 in FETCH or WAIT. memAck in VALID or HALT is ignored.

## Timing
- Reset (async, Reset=0):
  - curPC=RESET_PC, state FETCH.
  - memReq=0, instrValid=0, instr=0, halted=0.
- First memReq is asserted in the first cycle after Reset deasserts.
- Fetch latency: instrValid rises on the edge after the memAck cycle. With zero-wait memory (ack in FETCH) it takes 2 cycles from PC load to instrValid.
- PC update takes effect on the PCWre edge. memAddr shows the new PC in the following FETCH cycle.
- Once raised, memReq stays high until memAck is sampled.
- instrValid deasserts on the same edge the PC advances.
- Reset mid-WAIT drops memReq immediately (asynchronously). A memAck arriving after Reset deasserts is only honoured once a new request is issued.

## Test plan
- Reset with RESET_PC=0, ack in FETCH -> memAddr=0, instrValid at cycle 2, instr=memData; PCWre with seq -> next memAddr=4.
- Memory with 3-cycle wait -> memReq held 4 cycles with memAddr constant; instrValid one cycle after ack.
- Branch at PC=0x100, offset=-2 -> PC=0xFC; at PC=0xFFFF_FFFC seq -> PC=0x0000_0000.
- Jump at PC=0x4000_0010, target=0x0000040 -> PC=0x4000_0100; jr regAddr=0x1003 -> PC=0x1000.
- halt and PCWre together in VALID -> halted=1, PC unchanged, memReq stays 0 for 20 cycles.
- Reset pulsed during WAIT -> memReq low immediately, curPC=RESET_PC, refetch follows.
